sync_fifo_stream_rd: RTL and testbench

- Read-side adapter for the team's synchronous FIFO. It drains the FIFO's rd_en/rdata/fifo_empty read port and presents a registered valid/ready stream to a downstream consumer.
- It hides the FIFO's one-cycle registered read latency behind a 2-entry output buffer, so the stream sustains one word per clock when ready is held high.
- It sits between the FIFO and any valid/ready sink, clocked and cleared alongside the FIFO.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/stream_skid_buf.sv | 63 ++++++
 rtl/sync_fifo_stream_rd.sv | 57 +++++
 tb/tb_sync_fifo_stream_rd.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and credit helper for sync_fifo read-side logic
package fifo_pkg;

  // Cycles from rd_en to data on the FIFO's rdata port
  localparam int FIFO_RD_LAT = 1;

  // Entries in the output skid buffer that hides the read latency
  localparam int SKID_DEPTH = 2;

  // Widths derived from the buffer depth
  localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  // True when a new read can be issued without overflowing the buffer:
  // words already held plus the word in flight, minus the one leaving now.
  function automatic logic credit_ok(
    input logic [SKID_CNT_W-1:0] cnt,
    input logic                  inflight,
    input logic                  pop
  );
    logic [SKID_CNT_W:0] committed;
    committed = {1'b0, cnt} + (SKID_CNT_W + 1)'(inflight) - (SKID_CNT_W + 1)'(pop);
    return committed < (SKID_CNT_W + 1)'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - small register FIFO presenting a registered valid/data head
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [WIDTH-1:0]      head,
  output logic [SKID_CNT_W-1:0] cnt
);

  logic [WIDTH-1:0]      mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr;
  logic [SKID_PTR_W-1:0] rd_ptr;
  logic [SKID_CNT_W-1:0] cnt_q;
  logic [SKID_CNT_W-1:0] cnt_next;
  logic                  valid_q;

  // Occupancy after this cycle's push/pop; a simultaneous pair cancels out
  always_comb begin
    cnt_next = cnt_q + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
  end

  // Storage, pointers, count and the registered valid flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt_q   <= cnt_next;
      valid_q <= (cnt_next != '0);
    end
  end

  // Head is a register selected by a registered pointer, so no path from push_data
  assign head  = mem[rd_ptr];
  assign valid = valid_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/sync_fifo_stream_rd.sv
// rtl/sync_fifo_stream_rd.sv - drains a sync FIFO read port into a registered valid/ready stream
module sync_fifo_stream_rd
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  fifo_empty,
  input  logic [WIDTH-1:0]      fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic [SKID_CNT_W-1:0] buf_cnt
);

  // One bit per cycle of FIFO read latency; the oldest bit marks data on fifo_rdata
  logic [FIFO_RD_LAT-1:0] inflight;
  logic                   pop;
  logic                   push;

  assign pop  = m_valid & m_ready;
  // A word landing during clr belongs to the flushed stream and is dropped
  assign push = inflight[FIFO_RD_LAT-1] & ~clr;

  // Read only when the buffer is guaranteed room for the returning word
  assign fifo_rd_en = rst & ~fifo_empty & ~clr
                    & credit_ok(buf_cnt, inflight[FIFO_RD_LAT-1], pop);

  // Track the read issued this cycle so its data is captured next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else if (clr) begin
      inflight <= '0;
    end else begin
      inflight <= FIFO_RD_LAT'(fifo_rd_en);
    end
  end

  stream_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .push_data (fifo_rdata),
    .pop       (pop),
    .valid     (m_valid),
    .head      (m_data),
    .cnt       (buf_cnt)
  );

endmodule

// File: tb/tb_sync_fifo_stream_rd.sv
// tb/tb_sync_fifo_stream_rd.sv - directed and scoreboarded bench for sync_fifo_stream_rd
module tb_sync_fifo_stream_rd;

  localparam int WIDTH      = 32;
  localparam int FIFO_DEPTH = 16;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             clr        = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready    = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       buf_cnt;

  logic             wr_en   = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;

  int               checks    = 0;
  int               failures  = 0;
  int               cyc       = 0;
  int               pop_total = 0;
  int               pop_cyc[$];
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] data_prev = '0;

  always #5 clk = ~clk;

  sync_fifo_stream_rd #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .buf_cnt    (buf_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural sync FIFO: one-cycle read latency, registered empty flag
  always @(posedge clk) begin
    if (clr) begin
      fq.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        fifo_rdata <= fq.pop_front();
      end
      if (wr_en) begin
        fq.push_back(wr_data);
      end
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Scoreboard and stream-rule monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("buf_cnt_le2", 32'(buf_cnt <= 2'd2), 32'd1);
      if (hold_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", m_data, data_prev);
      end
      if (m_valid && m_ready) begin
        check("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("stream_data", m_data, exp_q.pop_front());
        end
        pop_total++;
        pop_cyc.push_back(cyc);
      end
      hold_prev = m_valid && !m_ready && !clr;
      data_prev = m_data;
      if (clr) begin
        exp_q.delete();
      end
      if (wr_en && !clr) begin
        exp_q.push_back(wr_data);
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (pop_total < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, pop_total, target);
  endtask

  initial begin
    int p0;
    int nw;
    int budget;

    // Reset and idle
    #2 rst = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_cnt", 32'(buf_cnt), 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
      check("idle_valid", 32'(m_valid), 32'd0);
      check("idle_cnt", 32'(buf_cnt), 32'd0);
    end

    // Single word latency: rd_en at N, valid at N+2, gone after pop
    m_ready = 1'b1;
    write_word(32'hA5A5_0001);
    check("single_rd_en_n", 32'(fifo_rd_en), 32'd1);
    check("single_valid_n", 32'(m_valid), 32'd0);
    tick();
    check("single_rd_en_n1", 32'(fifo_rd_en), 32'd0);
    check("single_valid_n1", 32'(m_valid), 32'd0);
    tick();
    check("single_valid_n2", 32'(m_valid), 32'd1);
    check("single_data_n2", m_data, 32'hA5A5_0001);
    tick();
    check("single_valid_n3", 32'(m_valid), 32'd0);

    // Streaming 0x1..0x10 with ready held high
    pop_cyc.delete();
    p0 = pop_total;
    for (int i = 1; i <= 16; i++) begin
      write_word(32'(i));
    end
    wait_pops(p0 + 16, 200, "stream_count");
    if (pop_cyc.size() == 16) begin
      check("stream_no_bubble", 32'(pop_cyc[15] - pop_cyc[0]), 32'd15);
    end
    repeat (3) tick();

    // Backpressure after the third word
    p0 = pop_total;
    nw = 0;
    for (int k = 0; k < 20; k++) begin
      if (pop_total - p0 >= 3) m_ready = 1'b0;
      if (nw < 8) begin
        wr_en   = 1'b1;
        wr_data = 32'h100 + 32'(nw);
        nw++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    check("bp_pops", 32'(pop_total - p0), 32'd3);
    check("bp_cnt", 32'(buf_cnt), 32'd2);
    check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_head", m_data, 32'h103);
    tick();
    check("bp_rd_en_hold", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    wait_pops(p0 + 8, 100, "bp_drain");

    // Random ready, 500 words through a 16-deep FIFO
    p0 = pop_total;
    nw = 0;
    budget = 0;
    while (pop_total - p0 < 500 && budget < 20000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (nw < 500 && fq.size() < FIFO_DEPTH - 1) begin
        wr_en   = 1'b1;
        wr_data = $urandom;
        nw++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      budget++;
    end
    wr_en   = 1'b0;
    m_ready = 1'b1;
    check("rand_count", 32'(pop_total - p0), 32'd500);
    repeat (3) tick();

    // clr with a read in flight and one word buffered
    m_ready = 1'b0;
    write_word(32'hC1);
    wr_en   = 1'b1;
    wr_data = 32'hC2;
    tick();
    wr_en = 1'b0;
    for (int k = 0; k < 10 && buf_cnt != 2'd1; k++) tick();
    check("clr_pre_cnt", 32'(buf_cnt), 32'd1);
    clr = 1'b1;
    #1;
    check("clr_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    clr = 1'b0;
    check("clr_valid", 32'(m_valid), 32'd0);
    check("clr_cnt", 32'(buf_cnt), 32'd0);
    p0 = pop_total;
    m_ready = 1'b1;
    write_word(32'h77);
    wait_pops(p0 + 1, 20, "post_clr_pop");
    repeat (4) tick();
    check("post_clr_extra", 32'(pop_total - p0), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
